// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller: register offsets, CTRL fields,
// scan states and the hex segment font.
package seg_scan_ctrl_pkg;

    // Word offsets, decoded from addr_i[3:2]
    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DP   = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MASK_LSB = 4;
    localparam int unsigned CTRL_IDX_LSB  = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StShow  = 2'd2
    } scan_state_e;

    // Entry k is the active-high a..g pattern for hex digit k
    localparam logic [15:0][6:0] HEX_FONT = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_scan_ctrl_decode.sv
// Combinational hex nibble to seven-segment (a..g) decoder.
module seg7_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_FONT[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Memory-mapped 4-digit seven-segment scan controller: registers, scan FSM with
// prescaler and ghost-suppression blanking, and registered pin drivers.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int unsigned      DIV_W        = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV  = DIV_W'(49999),
    parameter logic [7:0]       BLANK_CYCLES = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        r_en_i,
    input  logic        w_en_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] w_data_i,
    output logic [31:0] r_data_o,
    output logic [7:0]  pin_seg_o,
    output logic [3:0]  pin_seg_sel_o
);

    logic [15:0]      data_q;
    logic [3:0]       dp_q;
    logic             enable_q, enable_d;
    logic [3:0]       mask_q;
    logic [DIV_W-1:0] div_q;

    scan_state_e      state_q, state_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       blank_q, blank_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       sel_q, sel_d;

    logic       rd, wr;
    logic [1:0] reg_sel;
    logic       wr_data, wr_dp, wr_ctrl, wr_div;
    logic [3:0] nibble;
    logic [6:0] font_seg;
    logic       unused_bits;

    assign rd      = en_i & r_en_i;
    assign wr      = en_i & w_en_i;
    assign reg_sel = addr_i[3:2];
    assign wr_data = wr && (reg_sel == REG_DATA);
    assign wr_dp   = wr && (reg_sel == REG_DP);
    assign wr_ctrl = wr && (reg_sel == REG_CTRL);
    assign wr_div  = wr && (reg_sel == REG_DIV);

    assign unused_bits = ^{addr_i[31:4], addr_i[1:0], w_data_i[31:16]};

    always_comb begin
        r_data_o = '0;
        if (rd) begin
            case (reg_sel)
                REG_DATA: r_data_o[15:0] = data_q;
                REG_DP:   r_data_o[3:0]  = dp_q;
                REG_CTRL: begin
                    r_data_o[CTRL_EN_BIT]        = enable_q;
                    r_data_o[CTRL_MASK_LSB +: 4] = mask_q;
                    r_data_o[CTRL_IDX_LSB +: 2]  = idx_q;
                end
                REG_DIV:  r_data_o[DIV_W-1:0] = div_q;
                default:  r_data_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            dp_q     <= '0;
            enable_q <= 1'b0;
            mask_q   <= 4'hF;
            div_q    <= DEFAULT_DIV;
        end else begin
            if (wr_data) data_q <= w_data_i[15:0];
            if (wr_dp)   dp_q   <= w_data_i[3:0];
            if (wr_ctrl) begin
                enable_q <= w_data_i[CTRL_EN_BIT];
                mask_q   <= w_data_i[CTRL_MASK_LSB +: 4];
            end
            if (wr_div)  div_q  <= w_data_i[DIV_W-1:0];
        end
    end

    // FSM follows the post-write enable so a disabling write lands on the next edge
    assign enable_d = wr_ctrl ? w_data_i[CTRL_EN_BIT] : enable_q;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        idx_d   = idx_q;
        blank_d = blank_q;
        if (!enable_d) begin
            state_d = StIdle;
            presc_d = '0;
            idx_d   = '0;
            blank_d = '0;
        end else if (state_q == StIdle) begin
            presc_d = '0;
            idx_d   = '0;
            blank_d = BLANK_CYCLES;
            state_d = (BLANK_CYCLES == 8'd0) ? StShow : StBlank;
        end else begin
            if (state_q == StBlank) begin
                blank_d = blank_q - 8'd1;
                if (blank_q <= 8'd1) state_d = StShow;
            end
            // A digit change restarts blanking, even mid-blank when DIV is tiny
            if (wr_div) begin
                presc_d = '0;
            end else if (presc_q == div_q) begin
                presc_d = '0;
                idx_d   = idx_q + 2'd1;
                blank_d = BLANK_CYCLES;
                state_d = (BLANK_CYCLES == 8'd0) ? StShow : StBlank;
            end else begin
                presc_d = presc_q + 1'b1;
            end
        end
    end

    assign nibble = data_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble_i (nibble),
        .seg_o    (font_seg)
    );

    always_comb begin
        seg_d = 8'h00;
        sel_d = 4'hF;
        if (state_q == StShow && mask_q[idx_q]) begin
            seg_d = {dp_q[idx_q], font_seg};
            sel_d = ~(4'b0001 << idx_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            presc_q <= '0;
            idx_q   <= '0;
            blank_q <= '0;
            seg_q   <= 8'h00;
            sel_q   <= 4'hF;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            blank_q <= blank_d;
            seg_q   <= seg_d;
            sel_q   <= sel_d;
        end
    end

    assign pin_seg_o     = seg_q;
    assign pin_seg_sel_o = sel_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed scenarios plus randomized scan configurations
// checked against a closed-form timing model of the display scan.
module tb_seg_scan_ctrl;

    localparam logic [7:0]  BLANK  = 8'd2;
    localparam logic [31:0] A_DATA = 32'h0;
    localparam logic [31:0] A_DP   = 32'h4;
    localparam logic [31:0] A_CTRL = 32'h8;
    localparam logic [31:0] A_DIV  = 32'hC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, r_en, w_en;
    logic [31:0] addr, w_data, r_data;
    logic [7:0]  pin_seg;
    logic [3:0]  pin_sel;

    int total = 0;
    int bad   = 0;

    logic [6:0] font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(
        .DIV_W        (16),
        .DEFAULT_DIV  (16'd49999),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en_i          (en),
        .r_en_i        (r_en),
        .w_en_i        (w_en),
        .addr_i        (addr),
        .w_data_i      (w_data),
        .r_data_o      (r_data),
        .pin_seg_o     (pin_seg),
        .pin_seg_sel_o (pin_sel)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; w_en = 1'b1; r_en = 1'b0; addr = a; w_data = d;
        @(posedge clk);
        #1;
        en = 1'b0; w_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        en = 1'b1; r_en = 1'b1; w_en = 1'b0; addr = a;
        #1;
        d = r_data;
        en = 1'b0; r_en = 1'b0;
    endtask

    // Pins after edge E+t+1 reflect scan position t, where E is the enabling edge
    function automatic logic [11:0] model_pins(input int t, input int div, input logic [15:0] data,
                                               input logic [3:0] dp, input logic [3:0] mask);
        int p, d;
        logic [3:0] nib;
        p = t % (div + 1);
        d = (t / (div + 1)) % 4;
        if (p < int'(BLANK) || !mask[d]) return {8'h00, 4'hF};
        nib = 4'((data >> (4 * d)) & 16'hF);
        return {dp[d], font[nib], ~(4'b0001 << d)};
    endfunction

    function automatic logic [1:0] model_idx(input int t, input int div);
        return 2'((t / (div + 1)) % 4);
    endfunction

    task automatic start_scan(input int div, input logic [15:0] data, input logic [3:0] dp,
                              input logic [3:0] mask);
        bus_write(A_CTRL, 32'h0);
        @(posedge clk);
        #1;
        bus_write(A_DIV, 32'(div));
        bus_write(A_DATA, 32'(data));
        bus_write(A_DP, 32'(dp));
        bus_write(A_CTRL, (32'(mask) << 4) | 32'h1);
    endtask

    task automatic run_scan(input string name, input int div, input logic [15:0] data,
                            input logic [3:0] dp, input logic [3:0] mask, input int cycles);
        logic [31:0] rd, exp_ctrl;
        logic [11:0] exp;
        start_scan(div, data, dp, mask);
        for (int t = 0; t < cycles; t++) begin
            @(posedge clk);
            #1;
            exp = model_pins(t, div, data, dp, mask);
            total++;
            if ({pin_seg, pin_sel} !== exp) begin
                bad++;
                $display("FAIL %s pins t=%0d got=%h required=%h", name, t, {pin_seg, pin_sel}, exp);
            end
            bus_read(A_CTRL, rd);
            exp_ctrl = {22'b0, model_idx(t + 1, div), mask, 3'b000, 1'b1};
            total++;
            if (rd !== exp_ctrl) begin
                bad++;
                $display("FAIL %s ctrl t=%0d got=%h required=%h", name, t, rd, exp_ctrl);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        #12;
        total++;
        if ({pin_seg, pin_sel} !== 12'h00F) begin
            bad++;
            $display("FAIL reset_pins got=%h required=00f", {pin_seg, pin_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(A_DATA, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_data got=%h required=0", rd); end
        bus_read(A_DP, rd);
        total++;
        if (rd !== 32'h0) begin bad++; $display("FAIL reset_dp got=%h required=0", rd); end
        bus_read(A_CTRL, rd);
        total++;
        if (rd !== 32'h0F0) begin bad++; $display("FAIL reset_ctrl got=%h required=f0", rd); end
        bus_read(A_DIV, rd);
        total++;
        if (rd !== 32'd49999) begin bad++; $display("FAIL reset_div got=%h required=c34f", rd); end
    endtask

    task automatic test_scan();
        logic [7:0] seg_tab [4] = '{8'h66, 8'h4F, 8'h5B, 8'h06};
        logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [11:0] exp;
        start_scan(9, 16'h1234, 4'h0, 4'hF);
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1;
            if (t % 10 < 2) exp = 12'h00F;
            else            exp = {seg_tab[(t / 10) % 4], sel_tab[(t / 10) % 4]};
            total++;
            if ({pin_seg, pin_sel} !== exp) begin
                bad++;
                $display("FAIL scan_1234 t=%0d got=%h required=%h", t, {pin_seg, pin_sel}, exp);
            end
        end
    endtask

    task automatic test_random();
        int div;
        logic [15:0] data;
        logic [3:0] dp, mask;
        for (int i = 0; i < 4; i++) begin
            div  = int'($urandom_range(2, 12));
            data = 16'($urandom);
            dp   = 4'($urandom);
            mask = 4'($urandom);
            run_scan("random", div, data, dp, mask, 8 * (div + 1));
        end
    endtask

    task automatic test_idle();
        logic [31:0] rd;
        start_scan(5, 16'hBEEF, 4'hF, 4'hF);
        repeat (9) @(posedge clk);
        #1;
        bus_write(A_CTRL, 32'h0F0);
        @(posedge clk);
        #1;
        repeat (3) begin
            total++;
            if ({pin_seg, pin_sel} !== 12'h00F) begin
                bad++;
                $display("FAIL idle_pins got=%h required=00f", {pin_seg, pin_sel});
            end
            bus_read(A_CTRL, rd);
            total++;
            if (rd !== 32'h0F0) begin bad++; $display("FAIL idle_ctrl got=%h required=f0", rd); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_rw_same_cycle();
        logic [31:0] rd;
        bus_write(A_DATA, 32'h0000ABCD);
        @(negedge clk);
        en = 1'b1; r_en = 1'b1; w_en = 1'b1; addr = A_DATA; w_data = 32'h00005555;
        #1;
        total++;
        if (r_data !== 32'h0000ABCD) begin
            bad++;
            $display("FAIL rw_old got=%h required=abcd", r_data);
        end
        @(posedge clk);
        #1;
        en = 1'b0; r_en = 1'b0; w_en = 1'b0;
        bus_read(A_DATA, rd);
        total++;
        if (rd !== 32'h00005555) begin bad++; $display("FAIL rw_new got=%h required=5555", rd); end
        bus_write(A_DP, 32'hFFFFFFFF);
        bus_read(A_DP, rd);
        total++;
        if (rd !== 32'hF) begin bad++; $display("FAIL dp_unused got=%h required=f", rd); end
        bus_write(A_DIV, 32'hFFFF1234);
        bus_read(A_DIV, rd);
        total++;
        if (rd !== 32'h1234) begin bad++; $display("FAIL div_unused got=%h required=1234", rd); end
    endtask

    task automatic test_async_reset();
        logic [31:0] rd;
        start_scan(9, 16'h1234, 4'h0, 4'hF);
        repeat (26) @(posedge clk);
        #1;
        total++;
        if ({pin_seg, pin_sel} !== 12'h5BB) begin
            bad++;
            $display("FAIL digit2_before_reset got=%h required=5bb", {pin_seg, pin_sel});
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({pin_seg, pin_sel} !== 12'h00F) begin
            bad++;
            $display("FAIL async_reset_pins got=%h required=00f", {pin_seg, pin_sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus_read(A_CTRL, rd);
        total++;
        if (rd !== 32'h0F0) begin bad++; $display("FAIL post_reset_ctrl got=%h required=f0", rd); end
        bus_read(A_DIV, rd);
        total++;
        if (rd !== 32'd49999) begin bad++; $display("FAIL post_reset_div got=%h required=c34f", rd); end
        total++;
        if ({pin_seg, pin_sel} !== 12'h00F) begin
            bad++;
            $display("FAIL post_reset_pins got=%h required=00f", {pin_seg, pin_sel});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0; r_en = 1'b0; w_en = 1'b0;
        addr = '0; w_data = '0;
        test_reset();
        test_scan();
        run_scan("dp_8888", 9, 16'h8888, 4'h5, 4'hF, 40);
        run_scan("mask_6", 9, 16'h1234, 4'h0, 4'h6, 80);
        run_scan("blank_forever", 1, 16'h1234, 4'hF, 4'hF, 40);
        test_random();
        test_idle();
        test_rw_same_cycle();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Memory-mapped controller that time-multiplexes the 4-digit seven-segment display, so software writes a 16-bit hex value once instead of bit-banging segment and digit-select registers.
- Owns a refresh prescaler, a digit scan counter, a ghost-suppression blanking interval and a hex-to-segment decoder.
- Sits on the peripheral bus beside the GPIO block and drives the segment and select pins directly; the segment pins are used by one owner or the other, never both.

Parameters:
- DEFAULT_DIV, 16'd49999, reset value of the DIV register; digit period is DIV+1 clk cycles.
- BLANK_CYCLES, 8'd16, cycles all selects stay off after each digit change.
- DIV_W, 16, width of the DIV register and prescaler.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- en_i  input  1  block select from the address decoder
- r_en_i  input  1  bus read strobe
- w_en_i  input  1  bus write strobe
- addr_i  input  32  byte address; only [3:2] decoded
- w_data_i  input  32  write data
- r_data_o  output  32  read data, combinational, zero when not reading
- pin_seg_o  output  8  segments a..g = bits 0..6, dp = bit 7, active-high
- pin_seg_sel_o  output  4  digit selects, active-low, digit 0 = bit 0 (rightmost)

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Bus access: read = en_i & r_en_i, write = en_i & w_en_i. Writes take effect on the next clk edge. Reads are combinational in the same cycle.
- Register map, selected by addr_i[3:2]:
  - 0x0 DATA [15:0]: four hex nibbles; nibble k drives digit k.
  - 0x4 DP [3:0]: decimal point per digit.
  - 0x8 CTRL: [0] enable, [7:4] digit mask (1 = digit shown); read-only [9:8] current digit index.
  - 0xC DIV [DIV_W-1:0].
  - Unused bits read 0; writes to them are ignored.
- Reset values: DATA=0, DP=0, enable=0, mask=4'hF, DIV=DEFAULT_DIV, prescaler=0, digit index=0, blank counter=0, pin_seg_o=8'h00, pin_seg_sel_o=4'hF.
- States: IDLE (enable=0), BLANK, SHOW.
- IDLE:
  - Prescaler, digit index and blank counter held at 0; outputs seg=0, sel=4'hF.
  - enable 0->1 moves to BLANK with blank counter = BLANK_CYCLES.
  - If BLANK_CYCLES=0, go straight to SHOW.
- Prescaler: counts 0..DIV while enabled. At count==DIV:
  - prescaler returns to 0;
  - digit index advances (3 wraps to 0);
  - state goes to BLANK with blank counter = BLANK_CYCLES.
- BLANK: sel=4'hF, seg=0; blank counter decrements each cycle; at 1 go to SHOW. The prescaler keeps running in BLANK.
- SHOW:
  - seg = {DP[idx], hexfont(DATA nibble idx)}.
  - sel bit idx is driven low only if mask[idx]=1; a masked digit shows sel=4'hF and seg=0 for its slot, and scan timing is unchanged.
- Outputs are registered. A DATA/DP/mask write reaches the pins on the 2nd clk edge after the write cycle.
- Writing DIV clears the prescaler to 0 in the same edge; digit index and state are not changed.
- If DIV+1 <= BLANK_CYCLES, the display stays permanently blanked. This is legal and must not hang; scanning continues.
- A write of enable=0 returns to IDLE on the next edge, from any state.
- Read/write in the same cycle: read returns the old value.
- rst_n asserted mid-scan forces all reset values immediately (asynchronous), including the pins.
- Hex font, active-high segments: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.

Decomposition:
- Shared package: register offsets (0x0/0x4/0x8/0xC), CTRL bit positions, state encodings (IDLE/BLANK/SHOW), and the 16-entry font constants.
- Sub-module seg7_hex_decode: a combinational 4-bit nibble to 7-bit segment decoder, instantiated once on the muxed nibble.
- The top level holds the registers, FSM, prescaler and output flops.

Test Plan:
- Reset then read all four registers -> DATA=0, DP=0, CTRL=0x0F0, DIV=DEFAULT_DIV; pins seg=00, sel=F.
- DIV=9, BLANK_CYCLES=2, DATA=0x1234, DP=0, enable=1 -> digits cycle 0,1,2,3,0 every 10 cycles; each slot shows 2 cycles of sel=F then sel=E/seg=66 (4), D/4F (3), B/5B (2), 7/06 (1).
- DP=0x5 with DATA=0x8888 -> digits 0 and 2 show seg=FF, digits 1 and 3 show seg=7F.
- Mask=0x6 -> slots 0 and 3 always sel=F, seg=00; the 40-cycle scan period is unchanged.
- DIV=1, BLANK_CYCLES=2 -> sel stays F indefinitely while the CTRL[9:8] index still advances.
- rst_n pulsed low while digit 2 is showing -> pins go to seg=00, sel=F with no clk edge; CTRL reads 0x0F0 after release.
